// File: rtl/pht_update_scheduler.sv
// PHT update scheduler: queues two-lane branch resolutions, drains one per cycle, runs init sweeps.
// Optional same-cycle lane-1 bypass when the queue is idle: define PHT_UPD_BYPASS_EN.
module pht_update_scheduler #(
  parameter int DEPTH  = 4,
  parameter int IDX_W  = 5,
  parameter int ADDR_W = 8,
  parameter int GHR_W  = 5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       upd_valid1,
  input  logic [ADDR_W-1:0]          upd_addr1,
  input  logic [GHR_W-1:0]           upd_ghr1,
  input  logic                       upd_taken1,
  input  logic                       upd_valid2,
  input  logic [ADDR_W-1:0]          upd_addr2,
  input  logic [GHR_W-1:0]           upd_ghr2,
  input  logic                       upd_taken2,
  input  logic                       init_req,
  output logic                       upd_ready,
  output logic                       pht_wr_en,
  output logic [IDX_W-1:0]           pht_wr_idx,
  output logic                       pht_wr_init,
  output logic                       pht_wr_taken,
  output logic                       init_busy,
  output logic [$clog2(DEPTH):0]     q_count,
  output logic                       ovf_sticky
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t             state_reg;
  logic [IDX_W-1:0]   sweep_reg;
  logic [PTR_W-1:0]   wr_ptr_reg;
  logic [PTR_W-1:0]   rd_ptr_reg;
  logic [CNT_W-1:0]   count_reg;
  logic               ovf_reg;
  logic               wr_en_reg;
  logic [IDX_W-1:0]   wr_idx_reg;
  logic               wr_init_reg;
  logic               wr_taken_reg;
  logic               busy_reg;

  logic [IDX_W-1:0]   q_idx   [DEPTH];
  logic               q_taken [DEPTH];

  logic [IDX_W-1:0]   idx1;
  logic [IDX_W-1:0]   idx2;
  logic [CNT_W-1:0]   free_slots;
  logic               bypass1;
  logic               push1;
  logic               push2;
  logic               pop;
  logic               drop;
  logic [PTR_W-1:0]   slot2;
  logic [CNT_W-1:0]   count_next;
  logic               unused_addr_bits;

  assign idx1 = IDX_W'(upd_ghr1) ^ upd_addr1[IDX_W-1:0];
  assign idx2 = IDX_W'(upd_ghr2) ^ upd_addr2[IDX_W-1:0];
  assign unused_addr_bits = ^{upd_addr1[ADDR_W-1:IDX_W], upd_addr2[ADDR_W-1:IDX_W]};

  assign free_slots = CNT_W'(DEPTH) - count_reg;

`ifdef PHT_UPD_BYPASS_EN
  // Bypass only when the write port is otherwise idle this cycle.
  assign bypass1 = (state_reg == ST_RUN) && (count_reg == '0) && !wr_en_reg &&
                   upd_valid1 && !init_req;
`else
  assign bypass1 = 1'b0;
`endif

  // Lane 1 always claims the earlier slot; lane 2 only gets whatever remains.
  assign push1 = upd_valid1 && !bypass1 && !init_req && (free_slots != '0);
  assign push2 = upd_valid2 && !init_req && (free_slots > CNT_W'(push1));
  assign drop  = !init_req && ((upd_valid1 && !bypass1 && !push1) || (upd_valid2 && !push2));
  assign pop   = (state_reg == ST_RUN) && (count_reg != '0) && !init_req;
  assign slot2 = wr_ptr_reg + PTR_W'(push1);

  assign count_next = count_reg + CNT_W'(push1) + CNT_W'(push2) - CNT_W'(pop);

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        if (push1 && (wr_ptr_reg == PTR_W'(gi))) begin
          q_idx[gi]   <= idx1;
          q_taken[gi] <= upd_taken1;
        end else if (push2 && (slot2 == PTR_W'(gi))) begin
          q_idx[gi]   <= idx2;
          q_taken[gi] <= upd_taken2;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= ST_INIT;
      sweep_reg    <= '0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      ovf_reg      <= 1'b0;
      wr_en_reg    <= 1'b0;
      wr_idx_reg   <= '0;
      wr_init_reg  <= 1'b0;
      wr_taken_reg <= 1'b0;
      busy_reg     <= 1'b1;
    end else if (init_req) begin
      state_reg    <= ST_INIT;
      sweep_reg    <= '0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      wr_en_reg    <= 1'b0;
      wr_idx_reg   <= '0;
      wr_init_reg  <= 1'b0;
      wr_taken_reg <= 1'b0;
      busy_reg     <= 1'b1;
    end else begin
      ovf_reg    <= ovf_reg | drop;
      wr_ptr_reg <= wr_ptr_reg + PTR_W'(push1) + PTR_W'(push2);
      count_reg  <= count_next;
      case (state_reg)
        ST_INIT: begin
          wr_en_reg    <= 1'b1;
          wr_init_reg  <= 1'b1;
          wr_idx_reg   <= sweep_reg;
          wr_taken_reg <= 1'b0;
          busy_reg     <= 1'b1;
          sweep_reg    <= sweep_reg + 1'b1;
          if (sweep_reg == '1) begin
            state_reg <= ST_RUN;
          end
        end
        default: begin
          busy_reg    <= 1'b0;
          wr_init_reg <= 1'b0;
          if (pop) begin
            wr_en_reg    <= 1'b1;
            wr_idx_reg   <= q_idx[rd_ptr_reg];
            wr_taken_reg <= q_taken[rd_ptr_reg];
            rd_ptr_reg   <= rd_ptr_reg + 1'b1;
          end else begin
            wr_en_reg <= 1'b0;
          end
        end
      endcase
    end
  end

`ifdef PHT_UPD_BYPASS_EN
  assign pht_wr_en    = wr_en_reg | bypass1;
  assign pht_wr_idx   = bypass1 ? idx1 : wr_idx_reg;
  assign pht_wr_init  = bypass1 ? 1'b0 : wr_init_reg;
  assign pht_wr_taken = bypass1 ? upd_taken1 : wr_taken_reg;
`else
  assign pht_wr_en    = wr_en_reg;
  assign pht_wr_idx   = wr_idx_reg;
  assign pht_wr_init  = wr_init_reg;
  assign pht_wr_taken = wr_taken_reg;
`endif

  assign init_busy  = busy_reg;
  assign q_count    = count_reg;
  assign ovf_sticky = ovf_reg;
  assign upd_ready  = (free_slots >= CNT_W'(2));

endmodule

// File: tb/tb_pht_update_scheduler.sv
// Directed + randomized bench for pht_update_scheduler against a queue-based reference model.
module tb_pht_update_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic       upd_valid1, upd_taken1, upd_valid2, upd_taken2, init_req;
  logic [7:0] upd_addr1, upd_addr2;
  logic [4:0] upd_ghr1, upd_ghr2;
  logic       upd_ready, pht_wr_en, pht_wr_init, pht_wr_taken, init_busy, ovf_sticky;
  logic [4:0] pht_wr_idx;
  logic [2:0] q_count;

  always #5 clk = ~clk;

  pht_update_scheduler dut (
    .clk(clk), .rst(rst),
    .upd_valid1(upd_valid1), .upd_addr1(upd_addr1), .upd_ghr1(upd_ghr1), .upd_taken1(upd_taken1),
    .upd_valid2(upd_valid2), .upd_addr2(upd_addr2), .upd_ghr2(upd_ghr2), .upd_taken2(upd_taken2),
    .init_req(init_req), .upd_ready(upd_ready), .pht_wr_en(pht_wr_en), .pht_wr_idx(pht_wr_idx),
    .pht_wr_init(pht_wr_init), .pht_wr_taken(pht_wr_taken), .init_busy(init_busy),
    .q_count(q_count), .ovf_sticky(ovf_sticky)
  );

  int passed = 0;
  int total  = 0;
  int failed = 0;

  // Reference model: pending updates as a plain queue of {idx,taken}, sweep as a write counter.
  bit m_init;
  int m_sweep;
  int m_q[$];
  bit m_ovf;
  bit e_en, e_init, e_taken, e_busy;
  int e_idx;

  function automatic void m_reset();
    m_init = 1; m_sweep = 0; m_q.delete(); m_ovf = 0;
    e_en = 0; e_init = 0; e_taken = 0; e_idx = 0; e_busy = 1;
  endfunction

  function automatic void m_step();
    int free;
    int h;
    free = 4 - m_q.size();
    if (init_req) begin
      m_q.delete(); m_sweep = 0; m_init = 1;
      e_en = 0; e_init = 0; e_idx = 0; e_taken = 0; e_busy = 1;
      return;
    end
    if (m_init) begin
      e_en = 1; e_init = 1; e_idx = m_sweep; e_taken = 0; e_busy = 1;
      m_sweep++;
      if (m_sweep == 32) m_init = 0;
    end else begin
      e_busy = 0; e_init = 0;
      if (m_q.size() > 0) begin
        h = m_q.pop_front();
        e_en = 1; e_idx = h >> 1; e_taken = h & 1;
      end else begin
        e_en = 0;
      end
    end
    if (upd_valid1) begin
      if (free > 0) begin
        m_q.push_back((((int'(upd_ghr1) ^ int'(upd_addr1)) & 31) << 1) | int'(upd_taken1));
        free--;
      end else m_ovf = 1;
    end
    if (upd_valid2) begin
      if (free > 0) begin
        m_q.push_back((((int'(upd_ghr2) ^ int'(upd_addr2)) & 31) << 1) | int'(upd_taken2));
        free--;
      end else m_ovf = 1;
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("wr_en", 32'(pht_wr_en), 32'(e_en));
    if (e_en) begin
      chk("wr_idx", 32'(pht_wr_idx), 32'(e_idx));
      chk("wr_init", 32'(pht_wr_init), 32'(e_init));
      if (!e_init) chk("wr_taken", 32'(pht_wr_taken), 32'(e_taken));
    end
    chk("init_busy", 32'(init_busy), 32'(e_busy));
    chk("q_count", 32'(q_count), 32'(m_q.size()));
    chk("upd_ready", 32'(upd_ready), 32'((4 - m_q.size()) >= 2));
    chk("ovf", 32'(ovf_sticky), 32'(m_ovf));
  endtask

  task automatic step();
    @(posedge clk);
    if (rst) m_step(); else m_reset();
    #1;
    check_all();
    $display("t=%0t en=%0b idx=%0d init=%0b tk=%0b busy=%0b cnt=%0d rdy=%0b ovf=%0b",
             $time, pht_wr_en, pht_wr_idx, pht_wr_init, pht_wr_taken, init_busy, q_count,
             upd_ready, ovf_sticky);
  endtask

  task automatic idle();
    upd_valid1 = 0; upd_valid2 = 0; init_req = 0;
    upd_addr1 = '0; upd_ghr1 = '0; upd_taken1 = 0;
    upd_addr2 = '0; upd_ghr2 = '0; upd_taken2 = 0;
  endtask

  task automatic drive(input bit v1, input logic [7:0] a1, input logic [4:0] g1, input bit t1,
                       input bit v2, input logic [7:0] a2, input logic [4:0] g2, input bit t2,
                       input bit ir);
    upd_valid1 = v1; upd_addr1 = a1; upd_ghr1 = g1; upd_taken1 = t1;
    upd_valid2 = v2; upd_addr2 = a2; upd_ghr2 = g2; upd_taken2 = t2;
    init_req = ir;
  endtask

  task automatic run_to_idle();
    for (int i = 0; i < 50 && (m_init || m_q.size() > 0); i++) step();
    step();
  endtask

  initial begin
    rst = 0;
    idle();
    m_reset();
    // Reset state
    repeat (2) step();
    chk("rst_ready", 32'(upd_ready), 32'd1);
    chk("rst_busy", 32'(init_busy), 32'd1);
    @(negedge clk) rst = 1;

    // Overfill during the init sweep: 4 accepted, rest dropped
    for (int c = 0; c < 3; c++) begin
      drive(1, 8'($urandom), 5'($urandom), 1'($urandom), 1, 8'($urandom), 5'($urandom),
            1'($urandom), 0);
      step();
      if (c == 1) chk("full_ready", 32'(upd_ready), 32'd0);
    end
    idle();
    chk("full_ovf", 32'(ovf_sticky), 32'd1);
    chk("full_cnt", 32'(q_count), 32'd4);
    run_to_idle();
    chk("idle_en", 32'(pht_wr_en), 32'd0);
    chk("idle_busy", 32'(init_busy), 32'd0);

    // Single lane-1 update
    drive(1, 8'h13, 5'h05, 1, 0, 8'h00, 5'h00, 0, 0);
    step();
    idle();
    step();
    chk("l1_idx", 32'(pht_wr_idx), 32'h16);
    chk("l1_taken", 32'(pht_wr_taken), 32'd1);
    step();

    // Both lanes, same index: written in lane order
    drive(1, 8'h03, 5'h00, 0, 1, 8'h23, 5'h00, 1, 0);
    step();
    idle();
    step();
    chk("dual_first", {27'd0, pht_wr_idx} << 1 | 32'(pht_wr_taken), 32'h6);
    step();
    chk("dual_second", {27'd0, pht_wr_idx} << 1 | 32'(pht_wr_taken), 32'h7);
    step();

    // Queue 3 entries during a sweep, then flush with init_req
    drive(0, 8'h00, 5'h00, 0, 0, 8'h00, 5'h00, 0, 1);
    step();
    drive(1, 8'h11, 5'h02, 1, 1, 8'h44, 5'h07, 0, 0);
    step();
    drive(1, 8'h5a, 5'h1f, 1, 0, 8'h00, 5'h00, 0, 0);
    step();
    chk("flush_pre", 32'(q_count), 32'd3);
    drive(1, 8'h77, 5'h01, 1, 1, 8'h66, 5'h02, 1, 1);
    step();
    idle();
    chk("flush_cnt", 32'(q_count), 32'd0);
    step();
    chk("flush_idx0", 32'(pht_wr_idx), 32'd0);
    chk("flush_init", 32'(pht_wr_init), 32'd1);
    run_to_idle();

    // Randomized traffic with occasional re-init
    for (int c = 0; c < 400; c++) begin
      drive(1'($urandom_range(0, 1)), 8'($urandom), 5'($urandom), 1'($urandom),
            1'($urandom_range(0, 1)), 8'($urandom), 5'($urandom), 1'($urandom),
            $urandom_range(0, 99) == 0);
      step();
    end
    idle();
    run_to_idle();

    // Asynchronous reset mid-sweep at idx 10
    drive(0, 8'h00, 5'h00, 0, 0, 8'h00, 5'h00, 0, 1);
    step();
    idle();
    for (int c = 0; c < 11; c++) step();
    chk("mid_idx", 32'(pht_wr_idx), 32'd10);
    #2 rst = 0;
    #1;
    m_reset();
    chk("arst_en", 32'(pht_wr_en), 32'd0);
    chk("arst_idx", 32'(pht_wr_idx), 32'd0);
    chk("arst_busy", 32'(init_busy), 32'd1);
    chk("arst_ovf", 32'(ovf_sticky), 32'd0);
    chk("arst_ready", 32'(upd_ready), 32'd1);
    chk("arst_cnt", 32'(q_count), 32'd0);
    @(negedge clk) rst = 1;
    step();
    chk("restart_idx", 32'(pht_wr_idx), 32'd0);
    run_to_idle();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
